// File: rtl/mem_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_sequencer
// Purpose  : Hands one single-port memory (S-array RAM) to NUM_CH algorithm
//            loops in turn. Channel 0 owns the port first; every time the
//            owner raises its done level the port goes dark for one gap
//            cycle and passes to the next channel. After the last channel
//            the block parks in DONE until the next start pulse.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            start                   - pulse, begins a sequence from IDLE/DONE
//            ch_wren/ch_data/ch_addr - per-channel memory requests (packed)
//            ch_done                 - per-channel done level
//            ch_grant                - one-hot port ownership
//            mem_data/addr/wren      - registered memory port
//            active_ch               - current phase index
//            busy, all_done          - RUN/GAP and DONE indicators
//            timeout_err             - phase watchdog flag
// Options  : SEQ_TIMEOUT_EN - when defined, a per-phase watchdog of
//            TIMEOUT_CYCLES RUN cycles aborts the sequence into DONE.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_sequencer #(
    parameter int NUM_CH         = 3,
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [NUM_CH-1:0]                          ch_wren,
    input  logic [NUM_CH*DATA_W-1:0]                   ch_data,
    input  logic [NUM_CH*ADDR_W-1:0]                   ch_addr,
    input  logic [NUM_CH-1:0]                          ch_done,
    output logic [NUM_CH-1:0]                          ch_grant,
    output logic [DATA_W-1:0]                          mem_data,
    output logic [ADDR_W-1:0]                          mem_addr,
    output logic                                       mem_wren,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] active_ch,
    output logic                                       busy,
    output logic                                       all_done,
    output logic                                       timeout_err
);

    localparam int                c_KW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [c_KW-1:0]   c_LAST   = c_KW'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] c_GRANT0 = NUM_CH'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Elaboration-time guard on the configuration.
    if (NUM_CH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("mem_port_sequencer: NUM_CH and TIMEOUT_CYCLES must be >= 1");
    end

    logic [1:0]        r_state, w_state_nxt;
    logic [c_KW-1:0]   r_k, w_k_nxt, w_k_inc;
    logic [NUM_CH-1:0] r_grant, w_grant_nxt;
    logic [DATA_W-1:0] r_mem_data, w_data_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_addr_nxt;
    logic              r_mem_wren, w_wren_nxt;

`ifdef SEQ_TIMEOUT_EN
    localparam int              c_TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYCLES - 1);
    logic [c_TW-1:0] r_cnt, w_cnt_nxt;
    logic            r_tout, w_tout_nxt;
`endif

    assign w_k_inc = r_k + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_grant_nxt = '0;
        w_data_nxt  = r_mem_data;
        w_addr_nxt  = r_mem_addr;
        w_wren_nxt  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        // Counter only advances in RUN; any other state leaves it cleared,
        // so every entry into RUN starts the phase from zero.
        w_cnt_nxt   = '0;
        w_tout_nxt  = r_tout;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_k_nxt     = '0;
                    w_grant_nxt = c_GRANT0;
`ifdef SEQ_TIMEOUT_EN
                    w_tout_nxt  = 1'b0;
`endif
                end
            end
            S_RUN: begin
                w_grant_nxt = r_grant;
                if (ch_done[r_k]) begin
                    // Done cycle: this cycle's request is dropped and the
                    // port address/data freeze on their last values.
                    w_grant_nxt = '0;
                    w_state_nxt = S_GAP;
`ifdef SEQ_TIMEOUT_EN
                end else if (r_cnt == c_TO_LAST) begin
                    w_grant_nxt = '0;
                    w_state_nxt = S_DONE;
                    w_tout_nxt  = 1'b1;
`endif
                end else begin
                    w_data_nxt = ch_data[r_k*DATA_W +: DATA_W];
                    w_addr_nxt = ch_addr[r_k*ADDR_W +: ADDR_W];
                    w_wren_nxt = ch_wren[r_k];
`ifdef SEQ_TIMEOUT_EN
                    w_cnt_nxt  = r_cnt + 1'b1;
`endif
                end
            end
            S_GAP: begin
                if (r_k == c_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                    w_k_nxt     = w_k_inc;
                    w_grant_nxt = c_GRANT0 << w_k_inc;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_grant    <= '0;
            r_mem_data <= '0;
            r_mem_addr <= '0;
            r_mem_wren <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_k        <= w_k_nxt;
            r_grant    <= w_grant_nxt;
            r_mem_data <= w_data_nxt;
            r_mem_addr <= w_addr_nxt;
            r_mem_wren <= w_wren_nxt;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tout <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tout <= w_tout_nxt;
        end
    end
    assign timeout_err = r_tout;
`else
    assign timeout_err = 1'b0;
`endif

    assign ch_grant  = r_grant;
    assign mem_data  = r_mem_data;
    assign mem_addr  = r_mem_addr;
    assign mem_wren  = r_mem_wren;
    assign active_ch = r_k;
    assign busy      = (r_state == S_RUN) || (r_state == S_GAP);
    assign all_done  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_sequencer
// Purpose  : Directed self-checking bench for mem_port_sequencer. A 3-channel
//            instance covers the full sequence; a 1-channel instance covers
//            the degenerate RUN -> GAP -> DONE path. With SEQ_TIMEOUT_EN
//            defined the 3-channel instance uses a 10-cycle watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_sequencer;

`ifdef SEQ_TIMEOUT_EN
    localparam int c_TO = 10;
`else
    localparam int c_TO = 65535;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  ch_wren = '0;
    logic [23:0] ch_data = '0;
    logic [23:0] ch_addr = '0;
    logic [2:0]  ch_done = '0;
    logic [2:0]  ch_grant;
    logic [7:0]  mem_data, mem_addr;
    logic        mem_wren, busy, all_done, timeout_err;
    logic [1:0]  active_ch;

    logic        s_start = 1'b0, s_wren = 1'b0, s_done = 1'b0;
    logic [7:0]  s_data = '0, s_addr = '0;
    logic [0:0]  s_grant, s_active;
    logic [7:0]  s_mem_data, s_mem_addr;
    logic        s_mem_wren, s_busy, s_all_done, s_tout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_sequencer #(.NUM_CH(3), .DATA_W(8), .ADDR_W(8), .TIMEOUT_CYCLES(c_TO)) u_dut (
        .clk(clk), .reset(reset), .start(start), .ch_wren(ch_wren), .ch_data(ch_data),
        .ch_addr(ch_addr), .ch_done(ch_done), .ch_grant(ch_grant), .mem_data(mem_data),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .active_ch(active_ch), .busy(busy),
        .all_done(all_done), .timeout_err(timeout_err)
    );

    mem_port_sequencer #(.NUM_CH(1), .DATA_W(8), .ADDR_W(8), .TIMEOUT_CYCLES(c_TO)) u_dut1 (
        .clk(clk), .reset(reset), .start(s_start), .ch_wren(s_wren), .ch_data(s_data),
        .ch_addr(s_addr), .ch_done(s_done), .ch_grant(s_grant), .mem_data(s_mem_data),
        .mem_addr(s_mem_addr), .mem_wren(s_mem_wren), .active_ch(s_active), .busy(s_busy),
        .all_done(s_all_done), .timeout_err(s_tout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1;
        tick();
        checks++; if (ch_grant !== 3'b000) begin failures++; $display("FAIL rst_grant got=%b exp=000", ch_grant); end
        checks++; if (mem_data !== 8'h00 || mem_addr !== 8'h00) begin failures++; $display("FAIL rst_mem got=%h/%h exp=00/00", mem_data, mem_addr); end
        checks++; if (mem_wren !== 1'b0 || busy !== 1'b0 || all_done !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b%b exp=000", mem_wren, busy, all_done); end
        checks++; if (active_ch !== 2'd0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rst_idx got=%0d/%b exp=0/0", active_ch, timeout_err); end
        reset = 1'b0; start = 1'b0;
        tick();
        checks++; if (ch_grant !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL rst_start_ignored got=%b/%b exp=000/0", ch_grant, busy); end
    endtask

    task automatic test_start_write();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (ch_grant !== 3'b001 || busy !== 1'b1 || active_ch !== 2'd0) begin failures++; $display("FAIL start_grant got=%b/%b/%0d exp=001/1/0", ch_grant, busy, active_ch); end
        ch_addr = {8'h00, 8'h00, 8'h05}; ch_data = {8'h00, 8'h00, 8'hA5}; ch_wren = 3'b001;
        tick();
        checks++; if (mem_addr !== 8'h05 || mem_data !== 8'hA5 || mem_wren !== 1'b1) begin failures++; $display("FAIL ch0_write got=%h/%h/%b exp=05/A5/1", mem_addr, mem_data, mem_wren); end
    endtask

    task automatic test_interference();
        ch_wren = 3'b100; ch_done = 3'b010;
        ch_data = {8'h77, 8'h66, 8'h5A}; ch_addr = {8'h37, 8'h36, 8'h06};
        tick();
        checks++; if (mem_wren !== 1'b0 || mem_data !== 8'h5A || mem_addr !== 8'h06) begin failures++; $display("FAIL interf_port got=%b/%h/%h exp=0/5A/06", mem_wren, mem_data, mem_addr); end
        checks++; if (ch_grant !== 3'b001 || active_ch !== 2'd0) begin failures++; $display("FAIL interf_phase got=%b/%0d exp=001/0", ch_grant, active_ch); end
        ch_wren = 3'b101;
        tick();
        checks++; if (mem_wren !== 1'b1) begin failures++; $display("FAIL interf_wren got=%b exp=1", mem_wren); end
        ch_done = 3'b000;
    endtask

    task automatic test_sequence();
        ch_done = 3'b001; ch_wren = 3'b111; ch_data = {8'hC2, 8'hB1, 8'hEE};
        tick();
        checks++; if (ch_grant !== 3'b000 || mem_wren !== 1'b0 || mem_data !== 8'h5A || busy !== 1'b1) begin failures++; $display("FAIL done0 got=%b/%b/%h/%b exp=000/0/5A/1", ch_grant, mem_wren, mem_data, busy); end
        ch_done = 3'b000;
        tick();
        checks++; if (ch_grant !== 3'b010 || mem_wren !== 1'b0 || active_ch !== 2'd1) begin failures++; $display("FAIL gap0 got=%b/%b/%0d exp=010/0/1", ch_grant, mem_wren, active_ch); end
        tick();
        checks++; if (mem_data !== 8'hB1 || mem_addr !== 8'h36 || mem_wren !== 1'b1) begin failures++; $display("FAIL ch1_write got=%h/%h/%b exp=B1/36/1", mem_data, mem_addr, mem_wren); end
        ch_done = 3'b010;
        tick();
        checks++; if (ch_grant !== 3'b000 || mem_wren !== 1'b0 || mem_data !== 8'hB1) begin failures++; $display("FAIL done1 got=%b/%b/%h exp=000/0/B1", ch_grant, mem_wren, mem_data); end
        ch_done = 3'b000;
        tick();
        checks++; if (ch_grant !== 3'b100 || mem_wren !== 1'b0 || active_ch !== 2'd2) begin failures++; $display("FAIL gap1 got=%b/%b/%0d exp=100/0/2", ch_grant, mem_wren, active_ch); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (ch_grant !== 3'b100 || active_ch !== 2'd2 || mem_data !== 8'hC2 || all_done !== 1'b0) begin failures++; $display("FAIL run_start_ignored got=%b/%0d/%h/%b exp=100/2/C2/0", ch_grant, active_ch, mem_data, all_done); end
        ch_done = 3'b100;
        tick();
        checks++; if (ch_grant !== 3'b000 || all_done !== 1'b0 || busy !== 1'b1 || mem_wren !== 1'b0) begin failures++; $display("FAIL done2 got=%b/%b/%b/%b exp=000/0/1/0", ch_grant, all_done, busy, mem_wren); end
        ch_done = 3'b000;
        tick();
        checks++; if (all_done !== 1'b1 || busy !== 1'b0 || ch_grant !== 3'b000 || active_ch !== 2'd2 || mem_wren !== 1'b0) begin failures++; $display("FAIL all_done got=%b/%b/%b/%0d/%b exp=1/0/000/2/0", all_done, busy, ch_grant, active_ch, mem_wren); end
        tick();
        checks++; if (all_done !== 1'b1 || timeout_err !== 1'b0) begin failures++; $display("FAIL done_hold got=%b/%b exp=1/0", all_done, timeout_err); end
    endtask

    task automatic test_restart();
        ch_wren = 3'b000; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (all_done !== 1'b0 || ch_grant !== 3'b001 || busy !== 1'b1 || active_ch !== 2'd0) begin failures++; $display("FAIL restart got=%b/%b/%b/%0d exp=0/001/1/0", all_done, ch_grant, busy, active_ch); end
    endtask

    task automatic test_reset_mid();
        ch_done = 3'b001;
        tick();
        ch_done = 3'b000;
        tick();
        checks++; if (ch_grant !== 3'b010) begin failures++; $display("FAIL mid_setup got=%b exp=010", ch_grant); end
        ch_wren = 3'b010; ch_data = {8'h00, 8'h99, 8'h00}; reset = 1'b1; start = 1'b1;
        tick();
        checks++; if (mem_wren !== 1'b0 || ch_grant !== 3'b000 || busy !== 1'b0 || active_ch !== 2'd0 || mem_data !== 8'h00) begin failures++; $display("FAIL mid_reset got=%b/%b/%b/%0d/%h exp=0/000/0/0/00", mem_wren, ch_grant, busy, active_ch, mem_data); end
        reset = 1'b0; start = 1'b0; ch_wren = 3'b000;
        tick();
        checks++; if (ch_grant !== 3'b000 || busy !== 1'b0 || all_done !== 1'b0) begin failures++; $display("FAIL mid_idle got=%b/%b/%b exp=000/0/0", ch_grant, busy, all_done); end
    endtask

    task automatic test_single_ch();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        checks++; if (s_grant !== 1'b1 || s_busy !== 1'b1) begin failures++; $display("FAIL one_grant got=%b/%b exp=1/1", s_grant, s_busy); end
        s_wren = 1'b1; s_data = 8'h3C; s_addr = 8'h44;
        tick();
        checks++; if (s_mem_data !== 8'h3C || s_mem_addr !== 8'h44 || s_mem_wren !== 1'b1) begin failures++; $display("FAIL one_write got=%h/%h/%b exp=3C/44/1", s_mem_data, s_mem_addr, s_mem_wren); end
        s_done = 1'b1;
        tick();
        checks++; if (s_grant !== 1'b0 || s_mem_wren !== 1'b0 || s_busy !== 1'b1 || s_all_done !== 1'b0) begin failures++; $display("FAIL one_gap got=%b/%b/%b/%b exp=0/0/1/0", s_grant, s_mem_wren, s_busy, s_all_done); end
        s_done = 1'b0; s_wren = 1'b0;
        tick();
        checks++; if (s_all_done !== 1'b1 || s_busy !== 1'b0 || s_active !== 1'b0) begin failures++; $display("FAIL one_done got=%b/%b/%b exp=1/0/0", s_all_done, s_busy, s_active); end
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        reset = 1'b1;
        tick();
        reset = 1'b0; start = 1'b1; ch_done = 3'b000;
        tick();
        start = 1'b0;
        repeat (9) tick();
        checks++; if (timeout_err !== 1'b0 || all_done !== 1'b0 || ch_grant !== 3'b001) begin failures++; $display("FAIL to_early got=%b/%b/%b exp=0/0/001", timeout_err, all_done, ch_grant); end
        tick();
        checks++; if (timeout_err !== 1'b1 || all_done !== 1'b1 || ch_grant !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL to_fire got=%b/%b/%b/%b exp=1/1/000/0", timeout_err, all_done, ch_grant, busy); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (timeout_err !== 1'b0 || ch_grant !== 3'b001) begin failures++; $display("FAIL to_clear got=%b/%b exp=0/001", timeout_err, ch_grant); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_start_write();
        test_interference();
        test_sequence();
        test_restart();
        test_reset_mid();
        test_single_ch();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
